// File: rtl/button_event_classifier.sv
// Classifies debounced button presses into short / long / double-click pulses,
// with a held level and a wrapping event counter. Define BEC_REPEAT_EN for auto-repeat.
module button_event_classifier #(
    parameter int ClkFreq     = 100_000_000,
    parameter int LongPressMs = 1000,
    parameter int DoubleGapMs = 300,
    parameter int RepeatMs    = 200
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       db_level_i,
    output logic       short_o,
    output logic       long_o,
    output logic       double_o,
    output logic       repeat_o,
    output logic       held_o,
    output logic [7:0] event_cnt_o
);

    localparam int P        = ClkFreq / 1000;
    localparam int PS_W     = (P > 1) ? $clog2(P) : 1;
    localparam int BASE_MAX = (LongPressMs > DoubleGapMs) ? LongPressMs : DoubleGapMs;
`ifdef BEC_REPEAT_EN
    localparam int MS_MAX   = (RepeatMs > BASE_MAX) ? RepeatMs : BASE_MAX;
`else
    localparam int MS_MAX   = BASE_MAX;
`endif
    localparam int MS_W     = $clog2(MS_MAX + 1);

    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(P - 1);
    localparam logic [MS_W-1:0] MS_SAT   = '1;
    // Thresholds are matched one ms early, on the prescaler wrap that would reach them,
    // so the registered pulse lands exactly on the threshold cycle.
    localparam logic [MS_W-1:0] LONG_PRE = MS_W'(LongPressMs - 1);
    localparam logic [MS_W-1:0] GAP_PRE  = MS_W'(DoubleGapMs - 1);
`ifdef BEC_REPEAT_EN
    localparam logic [MS_W-1:0] REP_PRE  = MS_W'(RepeatMs - 1);
`endif

    if (ClkFreq < 1000 || (ClkFreq % 1000) != 0 || LongPressMs < 1 ||
        DoubleGapMs < 1 || RepeatMs < 1) begin : g_bad_param
        $error("button_event_classifier: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESSED,
        S_LONG_HELD,
        S_WAIT_SECOND,
        S_SECOND_PRESSED
    } state_t;

    state_t          state_reg, state_next;
    logic            lvl_reg;
    logic [PS_W-1:0] presc_reg, presc_next;
    logic [MS_W-1:0] ms_reg, ms_next;
    logic            short_reg, short_next;
    logic            long_reg, long_next;
    logic            double_reg, double_next;
    logic            held_reg, held_next;
    logic [7:0]      cnt_reg, cnt_next;
`ifdef BEC_REPEAT_EN
    logic            repeat_reg, repeat_next;
`endif

    logic rise, fall, tick, restart;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg  <= S_IDLE;
            lvl_reg    <= 1'b1;
            presc_reg  <= '0;
            ms_reg     <= '0;
            short_reg  <= 1'b0;
            long_reg   <= 1'b0;
            double_reg <= 1'b0;
            held_reg   <= 1'b0;
            cnt_reg    <= '0;
`ifdef BEC_REPEAT_EN
            repeat_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            lvl_reg    <= db_level_i;
            presc_reg  <= presc_next;
            ms_reg     <= ms_next;
            short_reg  <= short_next;
            long_reg   <= long_next;
            double_reg <= double_next;
            held_reg   <= held_next;
            cnt_reg    <= cnt_next;
`ifdef BEC_REPEAT_EN
            repeat_reg <= repeat_next;
`endif
        end
    end

    always_comb begin
        rise        = db_level_i & ~lvl_reg;
        fall        = ~db_level_i & lvl_reg;
        tick        = (presc_reg == PS_LAST);
        state_next  = state_reg;
        restart     = 1'b0;
        short_next  = 1'b0;
        long_next   = 1'b0;
        double_next = 1'b0;
`ifdef BEC_REPEAT_EN
        repeat_next = 1'b0;
`endif

        // Edges are tested before thresholds so an edge wins a same-cycle tie.
        case (state_reg)
            S_IDLE: begin
                if (rise) state_next = S_PRESSED;
            end
            S_PRESSED: begin
                if (fall) begin
                    state_next = S_WAIT_SECOND;
                end else if (tick && ms_reg == LONG_PRE) begin
                    state_next = S_LONG_HELD;
                    long_next  = 1'b1;
                end
            end
            S_LONG_HELD: begin
                if (fall) begin
                    state_next = S_IDLE;
                end
`ifdef BEC_REPEAT_EN
                else if (tick && ms_reg == REP_PRE) begin
                    repeat_next = 1'b1;
                    restart     = 1'b1;
                end
`endif
            end
            S_WAIT_SECOND: begin
                if (rise) begin
                    state_next  = S_SECOND_PRESSED;
                    double_next = 1'b1;
                end else if (tick && ms_reg == GAP_PRE) begin
                    state_next = S_IDLE;
                    short_next = 1'b1;
                end
            end
            S_SECOND_PRESSED: begin
                if (fall) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        if (state_next != state_reg) restart = 1'b1;

        if (restart) begin
            presc_next = '0;
            ms_next    = '0;
        end else if (tick) begin
            presc_next = '0;
            ms_next    = (ms_reg == MS_SAT) ? ms_reg : ms_reg + MS_W'(1);
        end else begin
            presc_next = presc_reg + PS_W'(1);
            ms_next    = ms_reg;
        end

        held_next = (state_next == S_LONG_HELD);
        cnt_next  = cnt_reg + {7'd0, short_next | long_next | double_next};
    end

    assign short_o     = short_reg;
    assign long_o      = long_reg;
    assign double_o    = double_reg;
    assign held_o      = held_reg;
    assign event_cnt_o = cnt_reg;
`ifdef BEC_REPEAT_EN
    assign repeat_o    = repeat_reg;
`else
    assign repeat_o    = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_classifier.sv
// Directed, table-driven bench for button_event_classifier with P=10, long=20 ms,
// gap=5 ms, repeat=4 ms; repeat expectations follow BEC_REPEAT_EN.
module tb_button_event_classifier;

    localparam int CLK_FREQ = 10_000;
    localparam int LONG_MS  = 20;
    localparam int GAP_MS   = 5;
    localparam int REP_MS   = 4;
`ifdef BEC_REPEAT_EN
    localparam int REP_EN   = 1;
`else
    localparam int REP_EN   = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       db_level;
    logic       short_o, long_o, double_o, repeat_o, held_o;
    logic [7:0] event_cnt;

    button_event_classifier #(
        .ClkFreq    (CLK_FREQ),
        .LongPressMs(LONG_MS),
        .DoubleGapMs(GAP_MS),
        .RepeatMs   (REP_MS)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .db_level_i (db_level),
        .short_o    (short_o),
        .long_o     (long_o),
        .double_o   (double_o),
        .repeat_o   (repeat_o),
        .held_o     (held_o),
        .event_cnt_o(event_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Pulse monitor: counts and timestamps of every observed pulse.
    int n_short = 0, n_long = 0, n_double = 0, n_repeat = 0;
    int last_short = -1, last_long = -1, last_double = -1;
    int last_repeat = -1, prev_repeat = -1;
    int held_rise = -1, held_fall = -1;
    int multi = 0, cnt_mism = 0;
    logic       held_prev = 1'b0;
    logic [7:0] model_cnt = 8'd0;

    always @(negedge clk) begin
        if (rst) begin
            model_cnt <= 8'd0;
            held_prev <= 1'b0;
        end else begin
            if (short_o)  begin n_short  <= n_short + 1;  last_short  <= cyc; end
            if (long_o)   begin n_long   <= n_long + 1;   last_long   <= cyc; end
            if (double_o) begin n_double <= n_double + 1; last_double <= cyc; end
            if (repeat_o) begin
                n_repeat    <= n_repeat + 1;
                prev_repeat <= last_repeat;
                last_repeat <= cyc;
            end
            if (int'(short_o) + int'(long_o) + int'(double_o) + int'(repeat_o) > 1)
                multi <= multi + 1;
            if (event_cnt != model_cnt + {7'd0, short_o | long_o | double_o})
                cnt_mism <= cnt_mism + 1;
            model_cnt <= model_cnt + {7'd0, short_o | long_o | double_o};
            if (held_o && !held_prev) held_rise <= cyc;
            if (!held_o && held_prev) held_fall <= cyc;
            held_prev <= held_o;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Holds the level for n cycles; t returns the first cycle it is seen by the DUT.
    task automatic drive(input logic v, input int n, output int t);
        @(posedge clk);
        #1;
        db_level = v;
        t = cyc;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        string name;
        int    hi1;
        int    lo1;
        int    hi2;
        int    exp_short;
        int    exp_long;
        int    exp_double;
        int    exp_repeat;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input vec_t v);
        int s, l, d, r, t;
        logic [7:0] c, dc;
        settle();
        s = n_short; l = n_long; d = n_double; r = n_repeat; c = event_cnt;
        drive(1'b1, v.hi1, t);
        drive(1'b0, v.lo1, t);
        if (v.hi2 > 0) begin
            drive(1'b1, v.hi2, t);
            drive(1'b0, 100, t);
        end
        settle();
        dc = event_cnt - c;
        check({v.name, " short"},  n_short - s,  v.exp_short);
        check({v.name, " long"},   n_long - l,   v.exp_long);
        check({v.name, " double"}, n_double - d, v.exp_double);
        check({v.name, " repeat"}, n_repeat - r, v.exp_repeat);
        check({v.name, " cnt"},    int'(dc),     v.exp_short + v.exp_long + v.exp_double);
        $display("vec %s: short=%0d long=%0d double=%0d repeat=%0d cnt=%0d",
                 v.name, n_short - s, n_long - l, n_double - d, n_repeat - r, event_cnt);
    endtask

    initial begin
        int t0, tf, tr, tx, s0, sum0;
        logic [7:0] dc;

        vecs[0] = '{"short80",      80, 100,   0, 1, 0, 0, 0};
        vecs[1] = '{"long250",     250, 100,   0, 0, 1, 0, REP_EN};
        vecs[2] = '{"double",       30,  20, 300, 0, 0, 1, 0};
        vecs[3] = '{"rel_at_thr",  200, 100,   0, 1, 0, 0, 0};
        vecs[4] = '{"rel_after",   201, 100,   0, 0, 1, 0, 0};
        vecs[5] = '{"long300",     300, 100,   0, 0, 1, 0, 2 * REP_EN};
        vecs[6] = '{"press_at_gap", 30,  50,  30, 0, 0, 1, 0};
        vecs[7] = '{"press_late",   30,  51,  30, 2, 0, 0, 0};
        vecs[8] = '{"one_cycle",     1, 100,   0, 1, 0, 0, 0};

        rst = 1'b1;
        db_level = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset short",  int'(short_o),  0);
        check("reset long",   int'(long_o),   0);
        check("reset double", int'(double_o), 0);
        check("reset repeat", int'(repeat_o), 0);
        check("reset held",   int'(held_o),   0);
        check("reset cnt",    int'(event_cnt), 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Exact short timing.
        drive(1'b1, 80, t0);
        drive(1'b0, 100, tf);
        settle();
        check("short cycle", last_short, tf + 51);
        $display("seq short: tf=%0d short_at=%0d", tf, last_short);

        // Long timing and held window.
        drive(1'b1, 250, t0);
        drive(1'b0, 100, tf);
        settle();
        check("long cycle",      last_long, t0 + 201);
        check("held rise cycle", held_rise, t0 + 201);
        check("held fall cycle", held_fall, tf + 1);
        $display("seq long: t0=%0d long_at=%0d held=%0d..%0d", t0, last_long, held_rise, held_fall);

        // Double-click timing.
        drive(1'b1, 30, tx);
        drive(1'b0, 20, tx);
        drive(1'b1, 300, tr);
        drive(1'b0, 100, tx);
        settle();
        check("double cycle", last_double, tr + 1);
        $display("seq double: tr=%0d double_at=%0d", tr, last_double);

        // Auto-repeat timing (absent without the repeat build).
        drive(1'b1, 300, t0);
        drive(1'b0, 100, tf);
        settle();
        check("repeat first cycle", prev_repeat, (REP_EN != 0) ? t0 + 241 : -1);
        check("repeat second cycle", last_repeat, (REP_EN != 0) ? t0 + 281 : -1);
        $display("seq repeat: t0=%0d repeats at %0d,%0d", t0, prev_repeat, last_repeat);

        // Reset in PRESSED with the button still held afterwards.
        drive(1'b1, 50, t0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async rst cnt",  int'(event_cnt), 0);
        check("async rst held", int'(held_o),    0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sum0 = n_short + n_long + n_double + n_repeat;
        repeat (300) @(posedge clk);
        drive(1'b0, 100, tx);
        settle();
        check("post-reset pulses", n_short + n_long + n_double + n_repeat - sum0, 0);
        check("post-reset cnt",    int'(event_cnt), 0);
        $display("seq reset: pulses=%0d cnt=%0d", n_short + n_long + n_double + n_repeat - sum0, event_cnt);

        // Counter wrap over 256 short presses.
        s0 = n_short;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 5, tx);
            drive(1'b0, 60, tx);
            if (i == 254) begin
                settle();
                check("cnt at 255", int'(event_cnt), 255);
            end
        end
        settle();
        dc = event_cnt;
        check("cnt wrapped", int'(dc), 0);
        check("wrap shorts", n_short - s0, 256);
        $display("seq wrap: shorts=%0d cnt=%0d", n_short - s0, event_cnt);

        check("multi-pulse cycles", multi, 0);
        check("cnt tracking errors", cnt_mism, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_event_classifier.md
# button_event_classifier

Downstream consumer of the debouncer: takes the debounced button level and classifies each press as a short press, long press or double click, emitting one-cycle event pulses. It also provides a held indication and an event counter. It sits between the debouncer output and the application control logic, which only ever sees clean, classified events.

## Interface

- `ClkFreq`, 100_000_000, clock frequency in Hz; must be a multiple of 1000 and ≥ 1000. P = ClkFreq/1000 cycles per ms.
- `LongPressMs`, 1000, hold duration (ms) for a long press; ≥ 1.
- `DoubleGapMs`, 300, maximum release-to-second-press gap (ms) for a double click; ≥ 1.
- `RepeatMs`, 200, auto-repeat period (ms) after a long press; ≥ 1; used only with `BEC_REPEAT_EN`.
- `clk_i`  input  1  system clock.
- `rst_i`  input  1  reset, asynchronous, active-high.
- `db_level_i`  input  1  debounced button level (1 = pressed), synchronous to `clk_i`.
- `short_o`  output  1  one-cycle pulse: short press classified.
- `long_o`  output  1  one-cycle pulse: long-press threshold reached.
- `double_o`  output  1  one-cycle pulse: double click detected.
- `repeat_o`  output  1  one-cycle auto-repeat pulse while long-held.
- `held_o`  output  1  level: high while in LONG_HELD.
- `event_cnt_o`  output  8  wrapping count of short/long/double events.

## Operation

- Edge detect: `lvl_q` registers `db_level_i`. rise = `db_level_i & ~lvl_q`, fall = `~db_level_i & lvl_q`.
- Timebase: prescaler counts 0..P-1. On wrap, the ms counter increments and saturates at its maximum. Both counters clear on every state transition.
- ms counter width: $clog2(max(LongPressMs, DoubleGapMs, RepeatMs)+1).
- FSM:
  - IDLE: rise → PRESSED.
  - PRESSED:
    - fall → WAIT_SECOND.
    - else ms == LongPressMs → LONG_HELD, pulse `long_o`.
  - LONG_HELD:
    - `held_o`=1.
    - fall → IDLE; no short.
    - With repeat enabled, each time ms reaches RepeatMs: pulse `repeat_o` and clear both counters.
  - WAIT_SECOND:
    - rise → SECOND_PRESSED, pulse `double_o`.
    - else ms == DoubleGapMs → IDLE, pulse `short_o`.
  - SECOND_PRESSED: fall → IDLE. No long or short is generated from the second press.
- Simultaneous events:
  - Edge has priority over threshold in the same cycle.
  - A release on the threshold cycle yields a short path, not a long.
  - A second press on the gap-expiry cycle yields double, not short.
- `event_cnt_o` increments by 1 on each `short_o`, `long_o` or `double_o` pulse, wrapping 255 → 0. `repeat_o` is not counted.
- All outputs are registered. At most one event pulse is asserted per cycle.

## Timing

- Reset values:
  - state = IDLE.
  - All pulses, `held_o` and `event_cnt_o` = 0.
  - Counters = 0.
  - `lvl_q` = 1, so a button held through reset produces no event until it is released and pressed again.
- T0 is the cycle in which a rise is detected. Counting starts at T0+1.
- `long_o` is high in cycle T0 + LongPressMs·P + 1. `held_o` rises in the same cycle.
- `double_o` is high in the cycle after the second rise is detected.
- `short_o` is high in cycle Tf + DoubleGapMs·P + 1, where Tf is the cycle the fall is detected.
- `held_o` falls in the cycle after the fall is detected.
- `repeat_o` is high every RepeatMs·P cycles, the first one RepeatMs·P cycles after `long_o`.
- `event_cnt_o` updates in the same cycle as the event pulse.
- Reset mid-operation: all outputs drop asynchronously, and any pending classification is discarded.

## Configuration

- `BEC_REPEAT_EN` defined: the auto-repeat logic is present, and `repeat_o` pulses as described.
- `BEC_REPEAT_EN` not defined: the repeat logic is not built, `repeat_o` is tied to 0, and `RepeatMs` does not affect counter width.

## Test plan

All scenarios use ClkFreq=10_000 (P=10), LongPressMs=20, DoubleGapMs=5, RepeatMs=4.

- Press 8 ms (80 cycles), then release and stay idle → one `short_o` at Tf+51, `event_cnt_o`=1, no other pulses.
- Hold 25 ms → `long_o` and `held_o`↑ at T0+201; `held_o`↓ one cycle after the fall detect; no `short_o`; `event_cnt_o`=1.
- Press 3 ms, release 2 ms, press again and hold 30 ms → `double_o` one cycle after the second rise; no `short_o` or `long_o`; `event_cnt_o`=1.
- Release exactly at the long threshold cycle (fall detected in cycle T0+200) → `short_o` path taken, no `long_o`.
- With `BEC_REPEAT_EN`, hold 30 ms → `long_o` at 20 ms, `repeat_o` at 24 ms and 28 ms (±1 cycle per the Timing section). Without the macro, `repeat_o` stays 0.
- Reset asserted mid-PRESSED with the button still high after reset deasserts → no events. Then 256 short presses → `event_cnt_o` wraps to 0.
